regwrite_trace_buffer: RTL

Captures the core's register write-back events (PC, destination register, write data) into a FIFO and drains them to a debug host over a valid/ready port. It sits beside `riscv`, tapping the write-back signals (`RegWrite`, `instructionAddress`, `instructionCurrent[11:7]`, `dataToWrite`). It gives in-system observation of register writes without simulator monitors. It also counts events lost to back-pressure and tags every event with a sequence number so gaps are detectable.

---
 rtl/regwrite_trace_buffer_pkg.sv | 30 +++
 rtl/regwrite_trace_buffer_fifo_mem.sv | 36 +++
 rtl/regwrite_trace_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/regwrite_trace_buffer_pkg.sv
// Shared definitions for the register write-back trace buffer.
// Entry layout, packed MSB to LSB: {seq, pc, rd, data}.
// The field widths and slice offsets below are used by both the top level
// and the storage array, so the entry format is defined only here.
package regwrite_trace_buffer_pkg;

  localparam int RD_W = 5;

  function automatic int entry_width(input int seq_w, input int xlen);
    return seq_w + xlen + RD_W + xlen;
  endfunction

  // Field LSB offsets inside a packed entry.
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int rd_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int pc_lsb(input int xlen);
    return xlen + RD_W;
  endfunction

  function automatic int seq_lsb(input int xlen);
    return xlen + RD_W + xlen;
  endfunction

endpackage

// File: rtl/regwrite_trace_buffer_fifo_mem.sv
// trace_fifo_mem: DEPTH x WIDTH register array for trace entries.
// One synchronous write port and one asynchronous read port.
// The storage is deliberately not reset; the top level masks the read data
// while the FIFO is empty, so stale contents are never observable.
// Ports:
//   clk      - write clock
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - entry to store
//   rd_addr  - read index
//   rd_data  - entry at rd_addr (combinational)
module trace_fifo_mem
  import regwrite_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 85
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/regwrite_trace_buffer.sv
// regwrite_trace_buffer: captures register write-back events (pc, rd, data)
// into a first-word-fall-through FIFO, tags each with a sequence number and
// drains them to a debug host over a valid/ready port. Events lost because
// the FIFO is full are counted (saturating) and flagged with a sticky bit.
// Ports:
//   clk, reset           - core clock; asynchronous active-low reset
//   capture_en           - gate for event capture
//   clear                - synchronous flush of FIFO, seq, drop counter, flag
//   wb_valid/pc/rd/data  - write-back tap from the core
//   out_valid/out_ready  - drain handshake
//   out_seq/pc/rd/data   - head entry (zero while out_valid=0)
//   level                - occupied entries
//   overflow             - sticky drop flag
//   drop_count           - dropped events, saturating
module regwrite_trace_buffer
  import regwrite_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [SEQ_W-1:0]         drop_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int EW      = entry_width(SEQ_W, XLEN);
  localparam int DATA_LO = data_lsb();
  localparam int RD_LO   = rd_lsb(XLEN);
  localparam int PC_LO   = pc_lsb(XLEN);
  localparam int SEQ_LO  = seq_lsb(XLEN);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;

  logic          empty;
  logic          full;
  logic          wb_event;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wb_event = capture_en & wb_valid & (wb_rd != 5'd0);
  assign pop      = ~empty & out_ready;
  // A pop frees the slot at the same edge, so a full FIFO can still accept.
  assign push     = wb_event & (~full | pop) & ~clear;
  assign drop     = wb_event & full & ~pop;

  assign wr_entry = {seq_q, wb_pc, wb_rd, wb_data};

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_entry)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    seq_d        = seq_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      seq_d        = '0;
      drop_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      // Sequence advances for dropped events too, leaving a visible gap.
      if (wb_event) begin
        seq_d = seq_q + SEQ_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != '1) begin
          drop_count_d = drop_count_q + SEQ_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      seq_q        <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      seq_q        <= seq_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Head fields are forced to zero while empty so unreset storage never leaks.
  assign out_valid  = ~empty;
  assign out_seq    = empty ? '0 : rd_entry[SEQ_LO  +: SEQ_W];
  assign out_pc     = empty ? '0 : rd_entry[PC_LO   +: XLEN];
  assign out_rd     = empty ? '0 : rd_entry[RD_LO   +: RD_W];
  assign out_data   = empty ? '0 : rd_entry[DATA_LO +: XLEN];
  assign level      = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
